mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  I-cache block-fill request; held high until i_done.
- i_addr  in  16  I-cache miss byte address.
- d_req  in  1  D-cache request; held high until d_done.
- d_addr  in  16  D-cache byte address.
- d_wr  in  1  1 = single-word write-through; 0 = block fill.
- d_wdata  in  16  D-cache write data.
- mem_en  out  1  memory request strobe.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid, 4 cycles after a read issue.
- fill_data  out  16  word to the cache being filled.
- fill_word  out  3  word index of fill_data within the block.
- fill_we_i  out  1  I-cache data-array write enable.
- fill_we_d  out  1  D-cache data-array write enable.
- i_done  out  1  one-cycle completion pulse, I side.
- d_done  out  1  one-cycle completion pulse, D side.
- busy  out  1  arbiter not in IDLE.

Function
REQ-002 SHALL implement states IDLE, FILL_I, FILL_D and WRITE_D.
REQ-003 In IDLE, one request SHALL be selected per cycle, entering the next state on the following edge:
- d_req & d_wr -> WRITE_D.
- d_req & !d_wr -> FILL_D.
- i_req -> FILL_I.
REQ-004 When d_req and i_req are both high, the winner SHALL follow REQ-016.
REQ-005 The selected request's address SHALL be latched at the grant edge.
- Block base = addr & 16'hFFF0 (8 words of 2 bytes).
REQ-006 Issue in FILL states:
- Issue counter ic (0..7) SHALL drive mem_en=1, mem_wr=0, mem_addr=base+2*ic for 8 consecutive cycles, starting in the first FILL cycle.
- mem_en SHALL be 0 once ic is exhausted.
REQ-007 Return in FILL states:
- Receive counter rc (0..7) SHALL increment on each mem_valid.
- fill_data=mem_rdata and fill_word=rc in that cycle.
- fill_we_i or fill_we_d (matching the state) SHALL be high only while mem_valid=1.
REQ-008 On the cycle the 8th mem_valid arrives (rc==7), i_done or d_done SHALL pulse, and the state SHALL return to IDLE on the next edge.
- Fill latency is 12 cycles from the first FILL cycle to done.
REQ-009 WRITE_D SHALL last exactly 1 cycle:
- mem_en=1, mem_wr=1, mem_addr=latched d_addr & 16'hFFFE, mem_wdata=latched d_wdata.
- d_done=1 in that same cycle.
- Return to IDLE.
REQ-010 Request deassertion or change mid-operation SHALL be ignored; the latched operation completes.
REQ-011 mem_valid in IDLE or WRITE_D SHALL be ignored; no fill_we and no counter change.
REQ-012 A request held high after its done pulse SHALL be treated as a new request in the next IDLE cycle.
- Minimum one IDLE cycle between operations.
REQ-013 busy SHALL be 1 in every non-IDLE state.
- All other outputs SHALL be 0 when not driven per REQ-006..REQ-009.

Reset
REQ-014 When rst_n=0 at a clk edge, the block SHALL:
- Enter IDLE and clear ic, rc, latched address/data and the priority bit.
- Drive all outputs 0 on the following cycle.
REQ-015 Reset mid-fill SHALL abort the fill with no done pulse.
- The memory shares rst_n, so no in-flight mem_valid survives.

Configuration
REQ-016 Arbitration mode SHALL depend on macro ARB_ROUND_ROBIN_EN:
- Defined: a last-served bit selects the side not served most recently when both request; the bit resets to "I served last", so D wins the first tie.
- Undefined: D side always wins ties (fixed priority); no last-served bit is present.

Structure
REQ-017 Package cpu_mem_pkg SHALL hold:
- BLOCK_WORDS=8, MEM_LATENCY=4, BLOCK_MASK=16'hFFF0.
- The state enum type.
- Shared with the cache modules.
REQ-018 Two-way priority selection SHALL live in one sub-module, arb_pick2, containing the optional round-robin bit.
- Counters and the FSM stay in mem_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- I fill: i_req, i_addr=16'h0136 -> mem_addr 0x0130..0x013E over 8 cycles; data D0..D7 -> fill_word 0..7, fill_we_i x8, i_done at cycle 12.
- D write: d_req, d_wr=1, d_addr=16'h2005, d_wdata=16'hBEEF -> one cycle mem_wr=1, mem_addr=0x2004, mem_wdata=0xBEEF, d_done same cycle.
- Tie: i_req and d_req (fill) asserted together twice in a row.
  - Fixed priority: D, I.
  - ARB_ROUND_ROBIN_EN: D first, then I.
- Mid-fill change: drop i_req after 3 cycles, raise d_req -> I fill still completes 8 words, then D is served.
- Reset at fill cycle 5 -> next cycle busy=0, mem_en=0, no i_done; a fresh i_req completes a full 8-word fill.
- Stray mem_valid in IDLE -> no fill_we_*, and rc stays 0 for the next fill.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Package     : cpu_mem_pkg
// Description : Shared constants and types for the CPU memory subsystem
//               (the memory arbiter and the I/D cache controllers).
//               Cache blocks are 8 words of 16 bits, so a block spans 16
//               bytes and the block base is the byte address with its low
//               four bits cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int          BLOCK_WORDS = 8;
    localparam int          MEM_LATENCY = 4;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL_I  = 2'd1,
        ST_FILL_D  = 2'd2,
        ST_WRITE_D = 2'd3
    } arb_state_e;

    // Byte address of word idx inside the block holding addr.
    function automatic logic [15:0] block_word_addr(input logic [15:0] addr,
                                                    input logic [2:0]  idx);
        return (addr & BLOCK_MASK) + {12'd0, idx, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick2.sv
// ============================================================================
// Module      : arb_pick2
// Description : Two-way priority selector between the I-cache and D-cache
//               request lines. Decides whether the D side wins this cycle.
//               Build macro ARB_ROUND_ROBIN_EN:
//                 defined   - a last-served bit favours the side not served
//                             most recently on a tie; it resets to
//                             "I served last", so D wins the first tie.
//                 undefined - fixed priority, D always wins a tie.
// Ports       : clk       in   clock
//               rst_n     in   synchronous active-low reset
//               i_req_i   in   I side requesting
//               d_req_i   in   D side requesting
//               grant_i   in   a grant is taken on the coming edge
//               d_wins_o  out  D side is selected (only when d_req_i=1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic grant_i,
    output logic d_wins_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = I side was served most recently.
    logic last_i_q;

    assign d_wins_o = d_req_i & (~i_req_i | last_i_q);

    // Every grant, contested or not, records who was served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_i_q <= 1'b1;
        end else if (grant_i) begin
            last_i_q <= ~d_wins_o;
        end
    end
`else
    assign d_wins_o = d_req_i;

    // Fixed priority keeps no state; these inputs exist for the common port list.
    logic unused_fixed_prio;
    assign unused_fixed_prio = clk ^ rst_n ^ i_req_i ^ grant_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a single memory port between I-cache block fills,
//               D-cache block fills and D-cache single-word write-throughs.
//               A fill issues 8 consecutive reads and collects 8 returns
//               (memory latency 4), writing each returned word into the
//               requesting cache's data array. Tie-break policy is selected
//               by build macro ARB_ROUND_ROBIN_EN (see arb_pick2).
// Ports       : clk, rst_n               clock, sync active-low reset
//               i_req/i_addr             I-cache fill request
//               d_req/d_addr/d_wr/d_wdata D-cache request
//               mem_en/mem_wr/mem_addr/mem_wdata  memory request side
//               mem_rdata/mem_valid      memory return side
//               fill_data/fill_word/fill_we_i/fill_we_d  cache fill port
//               i_done/d_done            one-cycle completion pulses
//               busy                     arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_we_i,
    output logic        fill_we_d,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    // Issue counter runs 0..8; 8 means all reads of the block have gone out.
    localparam logic [3:0] ISSUE_END = 4'(BLOCK_WORDS);
    localparam logic [2:0] RC_LAST   = 3'(BLOCK_WORDS - 1);

    arb_state_e  state_q;
    logic [3:0]  ic_q;
    logic [2:0]  rc_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    logic        grant;
    logic        d_wins;
    logic        in_fill;

    assign grant   = (state_q == ST_IDLE) && (i_req || d_req);
    assign in_fill = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);

    arb_pick2 u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .grant_i  (grant),
        .d_wins_o (d_wins)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ic_q <= '0;
                    rc_q <= '0;
                    if (d_wins) begin
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        state_q <= d_wr ? ST_WRITE_D : ST_FILL_D;
                    end else if (i_req) begin
                        addr_q  <= i_addr;
                        state_q <= ST_FILL_I;
                    end
                end
                ST_FILL_I, ST_FILL_D: begin
                    if (ic_q != ISSUE_END) begin
                        ic_q <= ic_q + 4'd1;
                    end
                    if (mem_valid) begin
                        rc_q <= rc_q + 3'd1;
                        if (rc_q == RC_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE_D: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs follow the registered state and counters; the
    // fill-port outputs must track mem_valid in the same cycle it arrives.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_data = '0;
        fill_word = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = (state_q != ST_IDLE);

        if (in_fill) begin
            if (ic_q != ISSUE_END) begin
                mem_en   = 1'b1;
                mem_addr = block_word_addr(addr_q, ic_q[2:0]);
            end
            if (mem_valid) begin
                fill_data = mem_rdata;
                fill_word = rc_q;
                if (state_q == ST_FILL_I) begin
                    fill_we_i = 1'b1;
                    i_done    = (rc_q == RC_LAST);
                end else begin
                    fill_we_d = 1'b1;
                    d_done    = (rc_q == RC_LAST);
                end
            end
        end else if (state_q == ST_WRITE_D) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q & 16'hFFFE;
            mem_wdata = wdata_q;
            d_done    = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A memory model answers
//               every read 4 cycles after issue; expected per-cycle outputs
//               of each operation are derived from the block rules, and the
//               arbitration winner from a last-served reference model.
//               Honours ARB_ROUND_ROBIN_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic [15:0] d_addr = '0;
    logic        d_wr = 1'b0;
    logic [15:0] d_wdata = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i, fill_we_d, i_done, d_done, busy;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hD0D0;
    endfunction

    // ---------------- memory model: latency 4, shares rst_n ----------------
    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;
    rd_t  rq[$];
    logic inj = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mem_en && !mem_wr) rq.push_back('{cyc + 4, mem_addr});
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) rq.delete();
        #1;
        mem_valid = 1'b0;
        mem_rdata = '0;
        if (inj) begin
            mem_valid = 1'b1;
            mem_rdata = 16'hDEAD;
        end else if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_valid = 1'b1;
            mem_rdata = memfn(rq[0].addr);
            void'(rq.pop_front());
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration: 1 = I was served most recently.
    logic m_last_i = 1'b1;

    function automatic logic predict_d(input logic ir, input logic dr);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return m_last_i;
`else
        return 1'b1;
`endif
    endfunction

    // Waits for the grant, then checks every cycle of one operation and the
    // idle cycle that follows. Entered and left just after a negedge.
    task automatic check_op(input logic side_d, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic midchg,
                            input logic [15:0] mid_daddr);
        int w;
        logic [15:0] base;
        base = addr & 16'hFFF0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (busy !== 1'b1 && w < 6);
        if (busy !== 1'b1) begin
            chk("grant_timeout", {31'd0, busy}, 32'd1);
            i_req = 1'b0;
            d_req = 1'b0;
            return;
        end
        if (wr) begin
            chk("wr_busy",   {31'd0, busy},   32'd1);
            chk("wr_en",     {31'd0, mem_en}, 32'd1);
            chk("wr_wr",     {31'd0, mem_wr}, 32'd1);
            chk("wr_addr",   {16'd0, mem_addr},  {16'd0, addr & 16'hFFFE});
            chk("wr_wdata",  {16'd0, mem_wdata}, {16'd0, wdata});
            chk("wr_d_done", {31'd0, d_done}, 32'd1);
            chk("wr_i_done", {31'd0, i_done}, 32'd0);
            chk("wr_we",     {30'd0, fill_we_i, fill_we_d}, 32'd0);
            d_req = 1'b0;
        end else begin
            for (int k = 0; k < 12; k++) begin
                if (k > 0) @(negedge clk);
                chk("fill_busy",  {31'd0, busy},   32'd1);
                chk("fill_en",    {31'd0, mem_en}, (k < 8) ? 32'd1 : 32'd0);
                chk("fill_wr",    {31'd0, mem_wr}, 32'd0);
                chk("fill_addr",  {16'd0, mem_addr}, (k < 8) ? {16'd0, 16'(base + 2*k)} : 32'd0);
                chk("fill_wdata", {16'd0, mem_wdata}, 32'd0);
                chk("fill_we_i",  {31'd0, fill_we_i}, (!side_d && k >= 4) ? 32'd1 : 32'd0);
                chk("fill_we_d",  {31'd0, fill_we_d}, ( side_d && k >= 4) ? 32'd1 : 32'd0);
                chk("fill_word",  {29'd0, fill_word}, (k >= 4) ? 32'(k - 4) : 32'd0);
                chk("fill_data",  {16'd0, fill_data},
                    (k >= 4) ? {16'd0, memfn(16'(base + 2*(k-4)))} : 32'd0);
                chk("i_done",     {31'd0, i_done}, (!side_d && k == 11) ? 32'd1 : 32'd0);
                chk("d_done",     {31'd0, d_done}, ( side_d && k == 11) ? 32'd1 : 32'd0);
                if (midchg && k == 2) begin
                    i_req  = 1'b0;
                    d_req  = 1'b1;
                    d_wr   = 1'b0;
                    d_addr = mid_daddr;
                end
                if (k == 11) begin
                    if (side_d) d_req = 1'b0;
                    else        i_req = 1'b0;
                end
            end
        end
        m_last_i = ~side_d;
        @(negedge clk);
        chk("idle_gap", {31'd0, busy}, 32'd0);
    endtask

    // One round: raise the given requests in an idle cycle and check every
    // operation they cause, in the expected order.
    task automatic run_round(input logic ir, input logic [15:0] ia, input logic dr,
                             input logic [15:0] da, input logic dw, input logic [15:0] dwd,
                             input logic first_d);
        i_req = ir; i_addr = ia;
        d_req = dr; d_addr = da; d_wr = dw; d_wdata = dwd;
        if (ir && dr) begin
            if (first_d) begin
                check_op(1'b1, dw, da, dwd, 1'b0, '0);
                check_op(1'b0, 1'b0, ia, '0, 1'b0, '0);
            end else begin
                check_op(1'b0, 1'b0, ia, '0, 1'b0, '0);
                check_op(1'b1, dw, da, dwd, 1'b0, '0);
            end
        end else if (dr) begin
            check_op(1'b1, dw, da, dwd, 1'b0, '0);
        end else begin
            check_op(1'b0, 1'b0, ia, '0, 1'b0, '0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic [15:0] da;
        logic        dw;
        logic [15:0] dwd;
        logic        exp_d;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 16'h2005, 1'b1, 16'hBEEF, 1'b1};
        tbl[1] = '{1'b1, 16'h0136, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 16'h0400, 1'b1, 16'h0810, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{1'b1, 16'h1234, 1'b1, 16'h4321, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 16'h7FFE, 1'b0, 16'h0000, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
        tbl[5] = '{1'b1, 16'h0A00, 1'b1, 16'h0B03, 1'b1, 16'hCAFE, 1'b0};
`else
        tbl[5] = '{1'b1, 16'h0A00, 1'b1, 16'h0B03, 1'b1, 16'hCAFE, 1'b1};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem",  {14'd0, mem_en, mem_wr, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_fill", {10'd0, fill_we_i, fill_we_d, fill_word, fill_data, i_done}, 32'd0);
        chk("rst_d_done", {31'd0, d_done}, 32'd0);
        rst_n = 1'b1;
        m_last_i = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_round(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].dw, tbl[i].dwd, tbl[i].exp_d);

        // Mid-fill change: I fill completes, then the newly raised D fill.
        i_req = 1'b1; i_addr = 16'h3008;
        check_op(1'b0, 1'b0, 16'h3008, '0, 1'b1, 16'h5000);
        check_op(1'b1, 1'b0, 16'h5000, '0, 1'b0, '0);
        d_req = 1'b0;

        // Reset at fill cycle 5.
        i_req = 1'b1; i_addr = 16'h6010;
        begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (busy !== 1'b1 && w < 6);
            chk("rst_mid_grant", {31'd0, busy}, 32'd1);
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            i_req = 1'b0;
            @(negedge clk);
            chk("rst_mid_busy",  {31'd0, busy},   32'd0);
            chk("rst_mid_en",    {31'd0, mem_en}, 32'd0);
            chk("rst_mid_done",  {31'd0, i_done}, 32'd0);
            chk("rst_mid_we",    {31'd0, fill_we_i}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            m_last_i = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("rst_after_idle", {29'd0, busy, i_done, fill_we_i}, 32'd0);
            end
        end
        run_round(1'b1, 16'h6010, 1'b0, '0, 1'b0, '0, 1'b0);

        // Stray mem_valid in IDLE.
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("stray_we",   {30'd0, fill_we_i, fill_we_d}, 32'd0);
        chk("stray_data", {13'd0, fill_word, fill_data}, 32'd0);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        run_round(1'b1, 16'h0F04, 1'b0, '0, 1'b0, '0, 1'b0);

        // Randomized rounds against the reference arbitration model.
        for (int r = 0; r < 30; r++) begin
            logic ir, dr, dw;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            run_round(ir, 16'($urandom), dr, 16'($urandom), dw, 16'($urandom), predict_d(ir, dr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
